// File: rtl/addr_decoder_mr_if.sv
// Bus bundle for the multi-region address decoder. The CPU memory stage
// drives the request side and the decoder answers with selects, completion,
// fault reporting and error statistics.
interface addr_decoder_mr_if #(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 4,
  parameter int ERRCNT_W    = 8
);
  logic                   req;
  logic [ADDR_W-1:0]      addr;
  logic                   err_clr;
  logic [NUM_REGIONS-1:0] cs;
  logic                   ack;
  logic                   err;
  logic                   busy;
  logic [ADDR_W-1:0]      err_addr;
  logic [ERRCNT_W-1:0]    err_count;

  modport master (
    output req, addr, err_clr,
    input  cs, ack, err, busy, err_addr, err_count
  );

  modport slave (
    input  req, addr, err_clr,
    output cs, ack, err, busy, err_addr, err_count
  );
endinterface

// File: rtl/addr_decoder_mr.sv
// Multi-region address decoder: decodes an address against NUM_REGIONS
// inclusive windows (lowest index wins on overlap), drives a registered
// one-hot chip select for the access, inserts per-region wait states before
// acknowledging, and reports unmapped addresses with a captured address and
// a saturating error counter.
module addr_decoder_mr #(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LO = (NUM_REGIONS*ADDR_W)'(32'h0000_09F0),
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_HI = (NUM_REGIONS*ADDR_W)'(32'h0000_1A13),
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WS = '0,
  parameter int ERRCNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  addr_decoder_mr_if.slave bus
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_FAULT
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [3:0]             wcnt;
  logic [NUM_REGIONS-1:0] cs_q;
  logic [ADDR_W-1:0]      err_addr_q;
  logic [ERRCNT_W-1:0]    err_count_q;

  logic                   hit_any;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_REGIONS-1:0] sel_onehot;
  logic [3:0]             sel_ws;
  logic                   start_hit;
  logic                   start_fault;
  logic                   ack_c;
  logic                   err_c;

  // Saturating increment for the error counter: holds at all-ones.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    if (&v) return v;
    return v + ERRCNT_W'(1);
  endfunction

  // Window decode; scanning from the top down lets the lowest index win.
  // A region whose LO exceeds HI can never satisfy both compares.
  always_comb begin
    hit_any = 1'b0;
    sel_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((bus.addr >= REGION_LO[i*ADDR_W +: ADDR_W]) &&
          (bus.addr <= REGION_HI[i*ADDR_W +: ADDR_W])) begin
        hit_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_onehot  = NUM_REGIONS'(1) << sel_idx;
  assign sel_ws      = REGION_WS[sel_idx*4 +: 4];
  assign start_hit   = (state == ST_IDLE) && bus.req && hit_any;
  assign start_fault = (state == ST_IDLE) && bus.req && !hit_any;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state and completion pulses.
  always_comb begin
    state_n = state;
    ack_c   = 1'b0;
    err_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (!hit_any)           state_n = ST_FAULT;
          else if (sel_ws != '0)  state_n = ST_WAIT;
          else                    state_n = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd1) state_n = ST_DONE;
      end
      ST_DONE: begin
        ack_c   = 1'b1;
        state_n = ST_IDLE;
      end
      ST_FAULT: begin
        err_c   = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Chip select and wait counter: loaded on a hit, held through the access,
  // dropped on the edge that returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q <= '0;
      wcnt <= '0;
    end else begin
      if (start_hit) begin
        cs_q <= sel_onehot;
        wcnt <= sel_ws;
      end else begin
        if (state == ST_WAIT) wcnt <= wcnt - 4'd1;
        if (state_n == ST_IDLE) cs_q <= '0;
      end
    end
  end

  // Fault capture; a new capture takes precedence over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (start_fault) begin
      err_addr_q  <= bus.addr;
      err_count_q <= bus.err_clr ? ERRCNT_W'(1) : sat_inc(err_count_q);
    end else if (bus.err_clr) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end
  end

  assign bus.cs        = cs_q;
  assign bus.ack       = ack_c;
  assign bus.err       = err_c;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.err_addr  = err_addr_q;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/addr_decoder_mr.md
Name: addr_decoder_mr

Overview:
- Parametrised multi-region address decoder with registered chip selects, per-region wait states, a req/ack handshake and bus-error capture.
- Sits between the CPU memory stage and the program/data/peripheral memories.
- Generalises the single fixed-window program-memory select to N configurable inclusive windows.
- Adds access sequencing plus fault reporting for unmapped addresses.

Parameters:
- ADDR_W, 32, address width in bits.
- NUM_REGIONS, 4, number of decoded windows (1..8).
- REGION_LO, packed NUM_REGIONS*ADDR_W, inclusive lower bound of each region; region i occupies slice [i*ADDR_W +: ADDR_W]. Default region0=0x000009F0, others 0.
- REGION_HI, packed NUM_REGIONS*ADDR_W, inclusive upper bound of each region. Default region0=0x00001A13, others 0.
- REGION_WS, packed NUM_REGIONS*4, wait states per region (0..15). Default all 0.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; held high with addr stable until ack or err.
- addr  in  ADDR_W  access address.
- cs  out  NUM_REGIONS  one-hot registered chip select.
- ack  out  1  one-cycle pulse: access completed.
- err  out  1  one-cycle pulse: unmapped address.
- busy  out  1  high in any state other than IDLE.
- err_addr  out  ADDR_W  address of the most recent unmapped access.
- err_count  out  ERRCNT_W  saturating count of unmapped accesses.
- err_clr  in  1  synchronous clear of err_count and err_addr.

Behaviour:
- Reset (async, rst=1): state=IDLE; cs=0, ack=0, err=0, busy=0, err_addr=0, err_count=0. Reset mid-access aborts it with no ack/err.
- Hit decode (combinational, internal): hit[i] = (addr >= LO[i]) && (addr <= HI[i]), unsigned compare.
  - Priority: the lowest index wins when regions overlap, so sel is always one-hot or zero.
  - A region with LO > HI never hits.
- FSM states: IDLE, WAIT, DONE, FAULT.
  - IDLE & req & any hit: cs <= onehot(sel); wcnt <= WS[sel]; next WAIT if WS[sel] != 0, else DONE.
  - IDLE & req & no hit: next FAULT; err_addr <= addr; err_count increments, saturating at all-ones.
  - WAIT: wcnt decrements each cycle; cs held; when wcnt == 1, next DONE.
  - DONE: ack=1 for this cycle; cs held this cycle; next IDLE; cs <= 0 on exit.
  - FAULT: err=1 for this cycle; cs=0; next IDLE.
- Latency from req sampled in IDLE:
  - ack is asserted WS+1 cycles after the sampling edge (WS=0 gives ack on the next cycle).
  - err is asserted 1 cycle after the sampling edge.
- After ack/err the FSM returns to IDLE. A req still high there is treated as a new access (back-to-back accesses cost one IDLE cycle each).
- req dropping in WAIT/DONE: the access completes anyway (no abort); addr is not re-sampled after IDLE.
- err_clr:
  - Zeroes err_count and err_addr on the next edge.
  - If it coincides with a new fault capture, the capture wins: err_addr = new address, err_count = 1.
- busy = (state != IDLE).
- ack and err are never high together; cs is zero in IDLE and FAULT.

Test Plan:
- Reset, default params, req with addr=0x000009F0 -> cs=0001, ack 1 cycle later; repeat with 0x00001A13 -> same; err never asserted.
- addr=0x000009EF, then 0x00001A14 -> err pulses; err_addr=0x00001A14; err_count=2; cs stays 0.
- REGION_WS region1=3 (region1 window 0x2000-0x2FFF), addr=0x2000 -> busy for 4 cycles, cs=0010 throughout, ack on cycle 4, cs=0 afterwards.
- Overlap: region0=0x0-0xFF, region2=0x80-0x1FF, addr=0x90 -> cs=0001 (priority); addr=0x100 -> cs=0100.
- ERRCNT_W=2, 5 unmapped accesses -> err_count saturates at 3; err_clr on the same cycle as a 6th fault -> err_count=1, err_addr=6th address.
- rst asserted during WAIT of a WS=5 access -> outputs zero immediately (async); after release, no spurious ack or err; the next access behaves normally.
